noc_out_port_alloc: RTL and testbench

//  Per-output-port switch allocator for the 5-port mesh router (N,S,E,W,L; 16-bit flits).

---
 rtl/noc_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/noc_out_port_alloc.sv | 125 ++++++++++++
 tb/tb_noc_out_port_alloc.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared router definitions: port naming, flit geometry and allocator states.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned FLIT_W    = 16;
  // Downstream input-buffer depth; default credit pool per output link
  localparam int unsigned BUF_DEPTH = 4;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan N positions starting at ptr; the first hit wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand = IDX_W'((int'(ptr) + i) % int'(N));
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/noc_out_port_alloc.sv
// Per-output-port switch allocator: round-robin among inputs, wormhole lock from
// head to tail flit, and credit tracking of the downstream buffer.
module noc_out_port_alloc
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN  = NUM_PORTS,
  parameter int unsigned CREDITS = BUF_DEPTH,
  parameter int unsigned CNT_W   = $clog2(CREDITS + 1),
  parameter int unsigned SEL_W   = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req_i,
  input  logic [NUM_IN-1:0] tail_i,
  input  logic              incr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  credits_o,
  output logic              locked_o,
  output logic              ovf_o
);

  alloc_state_e     state_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] owner_q;
  logic [CNT_W-1:0] credits_q;
  logic [SEL_W-1:0] sel_q;
  logic             ovf_q;

  logic              can_send;
  logic              arb_en;
  logic [NUM_IN-1:0] arb_gnt;
  logic [SEL_W-1:0]  arb_idx;
  logic [NUM_IN-1:0] gnt;
  logic [SEL_W-1:0]  win_idx;
  logic              valid;
  logic              win_tail;
  logic [SEL_W-1:0]  next_ptr;

  assign can_send = (credits_q != '0);
  assign arb_en   = can_send && (state_q == IDLE);

  rr_arbiter #(
    .N     (NUM_IN),
    .IDX_W (SEL_W)
  ) u_arb (
    .req (req_i),
    .ptr (rr_ptr_q),
    .en  (arb_en),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Grant selection: arbiter winner when idle, only the lock owner when locked.
  // Reset masks grants so nothing pops while state is being cleared.
  always_comb begin
    gnt     = '0;
    win_idx = arb_idx;
    if (state_q == LOCKED) begin
      win_idx      = owner_q;
      gnt[owner_q] = req_i[owner_q] & can_send;
    end else begin
      gnt = arb_gnt;
    end
    if (rst) begin
      gnt = '0;
    end
  end

  assign valid    = |gnt;
  assign win_tail = tail_i[win_idx];
  assign next_ptr = (win_idx == SEL_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;

  assign gnt_o     = gnt;
  assign valid_o   = valid;
  assign sel_o     = valid ? win_idx : sel_q;
  assign credits_o = credits_q;
  assign locked_o  = (state_q == LOCKED);
  assign ovf_o     = ovf_q;

  // Lock FSM, round-robin pointer, select hold register and credit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      credits_q <= CNT_W'(CREDITS);
      sel_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (valid) begin
        sel_q <= win_idx;
        unique case (state_q)
          IDLE: begin
            if (win_tail) begin
              rr_ptr_q <= next_ptr;
            end else begin
              state_q <= LOCKED;
              owner_q <= win_idx;
            end
          end
          LOCKED: begin
            if (win_tail) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_ptr;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // A send and a return in the same cycle cancel out
      if (valid && !incr_i) begin
        credits_q <= credits_q - 1'b1;
      end else if (incr_i && !valid) begin
        if (credits_q == CNT_W'(CREDITS)) begin
          ovf_q <= 1'b1;
        end else begin
          credits_q <= credits_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_out_port_alloc.sv
// Directed bench for the output-port allocator: inputs change on the falling edge,
// combinational outputs are checked 1 ns later, state commits on the rising edge.
module tb_noc_out_port_alloc;

  logic       clk;
  logic       rst;
  logic [4:0] req_i;
  logic [4:0] tail_i;
  logic       incr_i;
  logic [4:0] gnt_o;
  logic [2:0] sel_o;
  logic       valid_o;
  logic [2:0] credits_o;
  logic       locked_o;
  logic       ovf_o;

  int tests;
  int fails;

  noc_out_port_alloc dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .tail_i    (tail_i),
    .incr_i    (incr_i),
    .gnt_o     (gnt_o),
    .sel_o     (sel_o),
    .valid_o   (valid_o),
    .credits_o (credits_o),
    .locked_o  (locked_o),
    .ovf_o     (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] req, input logic [4:0] tail, input logic incr);
    req_i  = req;
    tail_i = tail;
    incr_i = incr;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Reset held two cycles with all inputs requesting
    rst = 1'b1;
    drive(5'b11111, 5'b00000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    tick();
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_credits", 32'(credits_o), 32'd4);
    chk("rst_locked", 32'(locked_o), 32'h0);
    chk("rst_ovf", 32'(ovf_o), 32'h0);
    chk("rst_sel", 32'(sel_o), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round robin over single-flit packets, credits replenished every cycle
    drive(5'b11111, 5'b11111, 1'b1);
    chk("rr0_gnt", 32'(gnt_o), 32'b00001); chk("rr0_sel", 32'(sel_o), 32'd0); tick(); #1;
    chk("rr1_gnt", 32'(gnt_o), 32'b00010); chk("rr1_sel", 32'(sel_o), 32'd1); tick(); #1;
    chk("rr2_gnt", 32'(gnt_o), 32'b00100); chk("rr2_sel", 32'(sel_o), 32'd2); tick(); #1;
    chk("rr3_gnt", 32'(gnt_o), 32'b01000); chk("rr3_sel", 32'(sel_o), 32'd3); tick(); #1;
    chk("rr4_gnt", 32'(gnt_o), 32'b10000); chk("rr4_sel", 32'(sel_o), 32'd4); tick(); #1;
    chk("rr5_gnt", 32'(gnt_o), 32'b00001); chk("rr5_sel", 32'(sel_o), 32'd0);
    chk("rr_credits", 32'(credits_o), 32'd4);
    tick();
    // Pointer is now 1

    // Wormhole: E sends head/body/tail while W keeps requesting
    drive(5'b01100, 5'b00000, 1'b1);
    chk("wh_head_gnt", 32'(gnt_o), 32'b00100); chk("wh_head_lock", 32'(locked_o), 32'd0);
    tick();
    drive(5'b01100, 5'b00000, 1'b1);
    chk("wh_body_gnt", 32'(gnt_o), 32'b00100); chk("wh_body_lock", 32'(locked_o), 32'd1);
    tick();
    drive(5'b01100, 5'b00100, 1'b1);
    chk("wh_tail_gnt", 32'(gnt_o), 32'b00100); chk("wh_tail_lock", 32'(locked_o), 32'd1);
    tick();
    drive(5'b01000, 5'b01000, 1'b1);
    chk("wh_w_gnt", 32'(gnt_o), 32'b01000); chk("wh_w_lock", 32'(locked_o), 32'd0);
    chk("wh_w_sel", 32'(sel_o), 32'd3);
    tick();
    drive(5'b00000, 5'b00000, 1'b0);
    chk("wh_idle_lock", 32'(locked_o), 32'd0);
    chk("wh_sel_hold", 32'(sel_o), 32'd3);
    chk("wh_credits", 32'(credits_o), 32'd4);
    tick();

    // Credit stall: L streams with no returns
    drive(5'b10000, 5'b10000, 1'b0);
    chk("cs0_gnt", 32'(gnt_o), 32'b10000); chk("cs0_cr", 32'(credits_o), 32'd4); tick(); #1;
    chk("cs1_gnt", 32'(gnt_o), 32'b10000); chk("cs1_cr", 32'(credits_o), 32'd3); tick(); #1;
    chk("cs2_gnt", 32'(gnt_o), 32'b10000); chk("cs2_cr", 32'(credits_o), 32'd2); tick(); #1;
    chk("cs3_gnt", 32'(gnt_o), 32'b10000); chk("cs3_cr", 32'(credits_o), 32'd1); tick(); #1;
    chk("cs_stall_gnt", 32'(gnt_o), 32'b00000);
    chk("cs_stall_valid", 32'(valid_o), 32'd0);
    chk("cs_stall_cr", 32'(credits_o), 32'd0);
    chk("cs_stall_sel", 32'(sel_o), 32'd4);
    tick();
    drive(5'b10000, 5'b10000, 1'b1);
    chk("cs_incr_gnt", 32'(gnt_o), 32'b00000);
    tick();
    drive(5'b10000, 5'b10000, 1'b0);
    chk("cs_one_gnt", 32'(gnt_o), 32'b10000); chk("cs_one_cr", 32'(credits_o), 32'd1);
    tick();
    drive(5'b10000, 5'b10000, 1'b0);
    chk("cs_again_gnt", 32'(gnt_o), 32'b00000); chk("cs_again_cr", 32'(credits_o), 32'd0);
    tick();

    // Simultaneous send and return, then overflow
    drive(5'b00000, 5'b00000, 1'b1); tick();
    drive(5'b00000, 5'b00000, 1'b1); tick();
    drive(5'b00001, 5'b00001, 1'b1);
    chk("sim_cr_before", 32'(credits_o), 32'd2);
    chk("sim_gnt", 32'(gnt_o), 32'b00001);
    tick();
    drive(5'b00000, 5'b00000, 1'b1);
    chk("sim_cr_after", 32'(credits_o), 32'd2);
    tick();
    drive(5'b00000, 5'b00000, 1'b1);
    chk("ovf_cr3", 32'(credits_o), 32'd3);
    tick();
    drive(5'b00000, 5'b00000, 1'b1);
    chk("ovf_cr4", 32'(credits_o), 32'd4); chk("ovf_pre", 32'(ovf_o), 32'd0);
    tick();
    drive(5'b00000, 5'b00000, 1'b0);
    chk("ovf_set", 32'(ovf_o), 32'd1); chk("ovf_cr_sat", 32'(credits_o), 32'd4);
    tick();
    #1;
    chk("ovf_sticky", 32'(ovf_o), 32'd1);

    // Reset mid-packet: S holds the lock (pointer is 1 after the N grant)
    drive(5'b00010, 5'b00000, 1'b1);
    chk("rm_head_gnt", 32'(gnt_o), 32'b00010);
    tick();
    drive(5'b00011, 5'b00000, 1'b1);
    chk("rm_lock", 32'(locked_o), 32'd1);
    chk("rm_owner_only", 32'(gnt_o), 32'b00010);
    tick();
    rst = 1'b1;
    drive(5'b00011, 5'b00000, 1'b0);
    chk("rm_rst_gnt", 32'(gnt_o), 32'b00000);
    tick();
    rst = 1'b0;
    drive(5'b00011, 5'b00011, 1'b0);
    chk("rm_unlocked", 32'(locked_o), 32'd0);
    chk("rm_ovf_clr", 32'(ovf_o), 32'd0);
    chk("rm_credits", 32'(credits_o), 32'd4);
    chk("rm_n_wins", 32'(gnt_o), 32'b00001);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
